// File: rtl/seg_operand_decoder_if.sv
// Bus bundle for seg_operand_decoder: glyph inputs, handshake and decoded results.
// The master side drives glyphs and start. The slave side is the decoder.
interface seg_operand_decoder_if;
    logic        enable_tick;
    logic        start;
    logic [7:0]  digit1;
    logic [7:0]  digit2;
    logic [7:0]  digit3;
    logic [7:0]  digit4;
    logic [6:0]  op_a;
    logic [6:0]  op_b;
    logic [13:0] value;
    logic        neg;
    logic        err;
    logic        err_disp;
    logic        valid;
    logic        busy;

    modport master (
        output enable_tick, start, digit1, digit2, digit3, digit4,
        input  op_a, op_b, value, neg, err, err_disp, valid, busy
    );

    modport slave (
        input  enable_tick, start, digit1, digit2, digit3, digit4,
        output op_a, op_b, value, neg, err, err_disp, valid, busy
    );
endinterface

// File: rtl/seg_operand_decoder.sv
// Recovers digits from four active-low seven-segment glyphs.
// It rebuilds op_a, op_b and the 4-digit value with a shift-add times-ten accumulator.
module seg_operand_decoder #(
    parameter int CLK_GATE = 0
) (
    input  logic                   clk_in,
    input  logic                   reset,
    seg_operand_decoder_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_ACCUM  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] K_DIGIT = 3'd0;
    localparam logic [2:0] K_MINUS = 3'd1;
    localparam logic [2:0] K_BLANK = 3'd2;
    localparam logic [2:0] K_E     = 3'd3;
    localparam logic [2:0] K_R     = 3'd4;
    localparam logic [2:0] K_BAD   = 3'd5;

    // Returns {kind, digit}. The dp bit is a don't-care in every pattern.
    function automatic logic [6:0] glyph_decode(input logic [7:0] seg);
        logic [6:0] r;
        casez (seg)
            8'b?100_0000: r = {K_DIGIT, 4'd0};
            8'b?111_1001: r = {K_DIGIT, 4'd1};
            8'b?010_0100: r = {K_DIGIT, 4'd2};
            8'b?011_0000: r = {K_DIGIT, 4'd3};
            8'b?001_1001: r = {K_DIGIT, 4'd4};
            8'b?001_0010: r = {K_DIGIT, 4'd5};
            8'b?000_0010: r = {K_DIGIT, 4'd6};
            8'b?111_1000: r = {K_DIGIT, 4'd7};
            8'b?000_0000: r = {K_DIGIT, 4'd8};
            8'b?001_0000: r = {K_DIGIT, 4'd9};
            8'b?011_1111: r = {K_MINUS, 4'd0};
            8'b?111_1111: r = {K_BLANK, 4'd0};
            8'b?000_0110: r = {K_E,     4'd0};
            8'b?010_1111: r = {K_R,     4'd0};
            default:      r = {K_BAD,   4'd0};
        endcase
        return r;
    endfunction

    function automatic logic [13:0] times10_14(input logic [13:0] x);
        return {x[10:0], 3'b000} + {x[12:0], 1'b0};
    endfunction

    function automatic logic [6:0] times10_7(input logic [6:0] x);
        return {x[3:0], 3'b000} + {x[5:0], 1'b0};
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [7:0]  glyph_q [4];
    logic [7:0]  glyph_d [4];
    logic [3:0]  dig_q [4];
    logic [3:0]  dig_d [4];
    logic        neg_f_q, neg_f_d;
    logic        err_f_q, err_f_d;
    logic        errd_f_q, errd_f_d;
    logic [13:0] acc_q, acc_d;
    logic [6:0]  pair_q, pair_d;
    logic [6:0]  op_a_q, op_a_d;
    logic [6:0]  op_b_q, op_b_d;
    logic [13:0] value_q, value_d;
    logic        neg_q, neg_d;
    logic        err_q, err_d;
    logic        err_disp_q, err_disp_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    logic        step_s;
    logic [2:0]  kind_s [4];
    logic [3:0]  digit_s [4];
    logic        any_bad_s, any_er_s, stray_minus_s, errd_pat_s, bad_s;
    logic        numeric_ok_s;
    logic [13:0] acc_next_s;
    logic [6:0]  pair_base_s, pair_next_s;

    // With gating disabled the FSM advances every clock; otherwise only on ticks.
    assign step_s = (CLK_GATE == 0) ? 1'b1 : bus.enable_tick;

    // Classify the captured glyphs and derive the display-level flags.
    always_comb begin
        any_bad_s     = 1'b0;
        any_er_s      = 1'b0;
        stray_minus_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            {kind_s[i], digit_s[i]} = glyph_decode(glyph_q[i]);
            any_bad_s = any_bad_s | (kind_s[i] == K_BAD);
            any_er_s  = any_er_s | (kind_s[i] == K_E) | (kind_s[i] == K_R);
            stray_minus_s = stray_minus_s | ((i != 0) && (kind_s[i] == K_MINUS));
        end
        errd_pat_s = (kind_s[0] == K_BLANK) && (kind_s[1] == K_E) &&
                     (kind_s[2] == K_R) && (kind_s[3] == K_R);
        bad_s = any_bad_s | stray_minus_s | (any_er_s & ~errd_pat_s);
    end

    // Next-state logic for the FSM, the accumulators and the result registers.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        glyph_d    = glyph_q;
        dig_d      = dig_q;
        neg_f_d    = neg_f_q;
        err_f_d    = err_f_q;
        errd_f_d   = errd_f_q;
        acc_d      = acc_q;
        pair_d     = pair_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        value_d    = value_q;
        neg_d      = neg_q;
        err_d      = err_q;
        err_disp_d = err_disp_q;
        valid_d    = 1'b0;

        numeric_ok_s = ~(err_f_q | errd_f_q);
        acc_next_s   = times10_14(acc_q) + {10'd0, dig_q[k_q]};
        pair_base_s  = (k_q == 2'd2) ? 7'd0 : pair_q;
        pair_next_s  = times10_7(pair_base_s) + {3'd0, dig_q[k_q]};

        case (state_q)
            S_IDLE: begin
                if (step_s && bus.start) begin
                    glyph_d[0] = bus.digit1;
                    glyph_d[1] = bus.digit2;
                    glyph_d[2] = bus.digit3;
                    glyph_d[3] = bus.digit4;
                    state_d    = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                if (step_s) begin
                    dig_d    = digit_s;
                    neg_f_d  = (kind_s[0] == K_MINUS);
                    err_f_d  = bad_s;
                    errd_f_d = errd_pat_s & ~bad_s;
                    acc_d    = 14'd0;
                    pair_d   = 7'd0;
                    k_d      = 2'd0;
                    state_d  = S_ACCUM;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_ACCUM: begin
                if (step_s) begin
                    acc_d  = acc_next_s;
                    pair_d = pair_next_s;
                    if (k_q == 2'd1) begin
                        op_a_d = numeric_ok_s ? pair_next_s : 7'd0;
                    end else begin
                        op_a_d = op_a_q;
                    end
                    if (k_q == 2'd3) begin
                        // Error and "Err" results suppress every numeric field, including neg.
                        value_d    = numeric_ok_s ? acc_next_s : 14'd0;
                        op_b_d     = numeric_ok_s ? pair_next_s : 7'd0;
                        neg_d      = neg_f_q & numeric_ok_s;
                        err_d      = err_f_q;
                        err_disp_d = errd_f_q;
                        valid_d    = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_DONE: begin
                if (step_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= S_IDLE;
            k_q        <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                glyph_q[i] <= 8'd0;
                dig_q[i]   <= 4'd0;
            end
            neg_f_q    <= 1'b0;
            err_f_q    <= 1'b0;
            errd_f_q   <= 1'b0;
            acc_q      <= 14'd0;
            pair_q     <= 7'd0;
            op_a_q     <= 7'd0;
            op_b_q     <= 7'd0;
            value_q    <= 14'd0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
            err_disp_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            glyph_q    <= glyph_d;
            dig_q      <= dig_d;
            neg_f_q    <= neg_f_d;
            err_f_q    <= err_f_d;
            errd_f_q   <= errd_f_d;
            acc_q      <= acc_d;
            pair_q     <= pair_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            value_q    <= value_d;
            neg_q      <= neg_d;
            err_q      <= err_d;
            err_disp_q <= err_disp_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.value    = value_q;
    assign bus.neg      = neg_q;
    assign bus.err      = err_q;
    assign bus.err_disp = err_disp_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_seg_operand_decoder.sv
// Directed bench for seg_operand_decoder: one ungated instance and one tick-gated instance.
module tb_seg_operand_decoder;

    logic clk_in = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_in = ~clk_in;

    seg_operand_decoder_if ifc ();
    seg_operand_decoder_if ifg ();

    seg_operand_decoder #(.CLK_GATE(0)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (ifc)
    );

    seg_operand_decoder #(.CLK_GATE(1)) dut_g (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (ifg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launch one decode on the ungated instance. Return the number of edges from the start edge to valid.
    task automatic run_decode(input logic [7:0] g1, input logic [7:0] g2,
                              input logic [7:0] g3, input logic [7:0] g4, output int lat);
        ifc.digit1 = g1;
        ifc.digit2 = g2;
        ifc.digit3 = g3;
        ifc.digit4 = g4;
        ifc.start  = 1'b1;
        @(negedge clk_in);
        ifc.start  = 1'b0;
        ifc.digit1 = 8'hAA;
        ifc.digit2 = 8'hAA;
        ifc.digit3 = 8'hAA;
        ifc.digit4 = 8'hAA;
        chk("busy_after_start", ifc.busy, 1);
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_in);
            if (ifc.valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int a, input int b, input int v,
                                input int n, input int e, input int ed);
        chk({tag, "_op_a"}, ifc.op_a, a);
        chk({tag, "_op_b"}, ifc.op_b, b);
        chk({tag, "_value"}, ifc.value, v);
        chk({tag, "_neg"}, ifc.neg, n);
        chk({tag, "_err"}, ifc.err, e);
        chk({tag, "_err_disp"}, ifc.err_disp, ed);
        @(negedge clk_in);
        chk({tag, "_valid_drop"}, ifc.valid, 0);
        chk({tag, "_busy_drop"}, ifc.busy, 0);
    endtask

    initial begin
        int lat;
        int pulses;
        int first_at;
        int second_at;
        int ticks;
        int g_at;

        reset = 1'b1;
        ifc.start = 1'b0; ifc.enable_tick = 1'b0;
        ifc.digit1 = 8'hFF; ifc.digit2 = 8'hFF; ifc.digit3 = 8'hFF; ifc.digit4 = 8'hFF;
        ifg.start = 1'b0; ifg.enable_tick = 1'b0;
        ifg.digit1 = 8'hFF; ifg.digit2 = 8'hFF; ifg.digit3 = 8'hFF; ifg.digit4 = 8'hFF;
        repeat (2) @(negedge clk_in);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_valid", ifc.valid, 0);
        chk("rst_value", ifc.value, 0);
        chk("rst_op_a", ifc.op_a, 0);
        chk("rst_err", ifc.err, 0);
        chk("rst_g_busy", ifg.busy, 0);
        reset = 1'b0;
        @(negedge clk_in);

        // "1234": valid follows edge N+5
        run_decode(8'hF9, 8'hA4, 8'hB0, 8'h99, lat);
        chk("lat_1234", lat, 5);
        check_result("d1234", 12, 34, 1234, 0, 0, 0);

        run_decode(8'hBF, 8'hC0, 8'hC0, 8'hF8, lat);
        chk("lat_m007", lat, 5);
        check_result("m007", 0, 7, 7, 1, 0, 0);

        run_decode(8'hFF, 8'h86, 8'hAF, 8'hAF, lat);
        chk("lat_errdisp", lat, 5);
        check_result("errdisp", 0, 0, 0, 0, 0, 1);

        run_decode(8'hC0, 8'hBF, 8'hC0, 8'hC0, lat);
        chk("lat_badminus", lat, 5);
        check_result("badminus", 0, 0, 0, 0, 1, 0);

        run_decode(8'h90, 8'h90, 8'h90, 8'h90, lat);
        chk("lat_9999", lat, 5);
        check_result("d9999", 99, 99, 9999, 0, 0, 0);

        run_decode(8'h10, 8'h10, 8'h10, 8'h10, lat);
        chk("lat_9999dp", lat, 5);
        check_result("d9999dp", 99, 99, 9999, 0, 0, 0);

        run_decode(8'hC0, 8'hC0, 8'h86, 8'hC0, lat);
        chk("lat_strayE", lat, 5);
        check_result("strayE", 0, 0, 0, 0, 1, 0);

        // Starts at N+3 (ACCUM) and N+6 (DONE) are ignored. The start at N+7 is accepted.
        ifc.digit1 = 8'hF9; ifc.digit2 = 8'hA4; ifc.digit3 = 8'hB0; ifc.digit4 = 8'h99;
        pulses = 0; first_at = -1; second_at = -1;
        for (int c = 0; c < 16; c++) begin
            ifc.start = (c == 0 || c == 3 || c == 6 || c == 7) ? 1'b1 : 1'b0;
            @(negedge clk_in);
            if (ifc.valid === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = c;
                else second_at = c;
            end
        end
        ifc.start = 1'b0;
        chk("restart_pulses", pulses, 2);
        chk("restart_first", first_at, 5);
        chk("restart_second", second_at, 12);

        // Reset at edge N+3 aborts the decode and clears the outputs.
        ifc.start = 1'b1;
        @(negedge clk_in);
        ifc.start = 1'b0;
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        chk("abort_busy", ifc.busy, 0);
        chk("abort_valid", ifc.valid, 0);
        chk("abort_op_a", ifc.op_a, 0);
        chk("abort_op_b", ifc.op_b, 0);
        chk("abort_value", ifc.value, 0);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_in);
            if (ifc.valid === 1'b1) pulses++;
        end
        chk("abort_no_valid", pulses, 0);

        // Gated instance: one tick every 4th cycle, so valid lands on the 6th tick.
        ifg.digit1 = 8'hF9; ifg.digit2 = 8'hA4; ifg.digit3 = 8'hB0; ifg.digit4 = 8'h99;
        ticks = 0; g_at = -1;
        for (int c = 0; c < 40; c++) begin
            ifg.enable_tick = (c % 4 == 0) ? 1'b1 : 1'b0;
            ifg.start = (c == 0) ? 1'b1 : 1'b0;
            @(negedge clk_in);
            if (ifg.enable_tick) ticks++;
            if (ifg.valid === 1'b1) begin
                g_at = c;
                break;
            end
        end
        ifg.start = 1'b0;
        ifg.enable_tick = 1'b0;
        chk("gated_ticks", ticks, 6);
        chk("gated_cycle", g_at, 20);
        chk("gated_value", ifg.value, 1234);
        chk("gated_op_a", ifg.op_a, 12);
        @(negedge clk_in);
        chk("gated_valid_drop", ifg.valid, 0);
        chk("gated_busy_done", ifg.busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
